// File: rtl/kim_muldiv_ctrl_p.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Latency: W+1 cycles from the start edge to done; a divide by zero finishes in 1 cycle.
// Backpressure: o_busy is high while an op is in flight; start and MTHI/MTLO writes are ignored while busy.
module kim_muldiv_ctrl_p #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_flush,
  input  logic                  i_hilo_we,
  input  logic                  i_hilo_sel,
  input  logic [DATA_WIDTH-1:0] i_hilo_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_div_by_zero,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_ZDIV} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div, r_neg_q, r_neg_r, r_done, r_dbz;
  logic [W-1:0]    r_opa;      // multiplicand (multiply) or divisor (divide)
  logic [2*W-1:0]  r_acc;      // {upper, multiplier} or {remainder, quotient}
  logic [W-1:0]    r_hi, r_lo;

  logic            w_signed, w_accept, w_zdiv;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic [W:0]      w_rem_s;
  logic [W+1:0]    w_add_x, w_add_y, w_sum;
  logic            w_cin;
  logic [2*W-1:0]  w_acc_nxt, w_prod_neg;
  logic [W-1:0]    w_quot_neg, w_rem_neg, w_res_hi, w_res_lo;

  // Operand magnitudes are only taken for the signed ops; unsigned ops use raw bits.
  assign w_signed = i_op[0];
  assign w_a_mag  = (w_signed && i_a[W-1]) ? -i_a : i_a;
  assign w_b_mag  = (w_signed && i_b[W-1]) ? -i_b : i_b;
  assign w_zdiv   = i_op[1] && (i_b == '0);
  // A flush in the same cycle as start wins: the start is dropped.
  assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;

  // Shared adder: add multiplicand for multiply, subtract divisor (a + ~b + 1) for divide.
  always_comb begin
    w_rem_s = {r_acc[2*W-1:W], r_acc[W-1]};
    w_add_x = {2'b00, r_acc[2*W-1:W]};
    w_add_y = {2'b00, r_opa};
    w_cin   = 1'b0;
    if (r_is_div) begin
      w_add_x = {1'b0, w_rem_s};
      w_add_y = ~{2'b00, r_opa};
      w_cin   = 1'b1;
    end
    w_sum = w_add_x + w_add_y + {{(W+1){1'b0}}, w_cin};
  end

  // One iteration step: shift-add multiply or restoring divide; bit W+1 of the sum is the borrow.
  always_comb begin
    w_acc_nxt = {1'b0, r_acc[2*W-1:1]};
    if (r_is_div) begin
      if (!w_sum[W+1]) w_acc_nxt = {w_sum[W-1:0], r_acc[W-2:0], 1'b1};
      else             w_acc_nxt = {w_rem_s[W-1:0], r_acc[W-2:0], 1'b0};
    end else if (r_acc[0]) begin
      w_acc_nxt = {w_sum[W:0], r_acc[W-1:1]};
    end
  end

  // Sign fix-up: negate the whole product, or quotient and remainder independently.
  always_comb begin
    w_prod_neg = -r_acc;
    w_quot_neg = -r_acc[W-1:0];
    w_rem_neg  = -r_acc[2*W-1:W];
    if (r_is_div) begin
      w_res_hi = r_neg_r ? w_rem_neg  : r_acc[2*W-1:W];
      w_res_lo = r_neg_q ? w_quot_neg : r_acc[W-1:0];
    end else begin
      w_res_hi = r_neg_q ? w_prod_neg[2*W-1:W] : r_acc[2*W-1:W];
      w_res_lo = r_neg_q ? w_prod_neg[W-1:0]   : r_acc[W-1:0];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; flush returns any busy state to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_zdiv ? S_ZDIV : S_RUN;
      S_RUN: begin
        if (i_flush)                      w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(W-1))       w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      S_ZDIV:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write-back and MTHI/MTLO.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opa    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= i_op[1];
            r_neg_q  <= w_signed & (i_a[W-1] ^ i_b[W-1]);
            r_neg_r  <= w_signed & i_a[W-1];
            // Divide-by-zero keeps the raw dividend so it can be returned in HI.
            r_opa    <= i_op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{W{1'b0}}, i_op[1] ? (w_zdiv ? i_a : w_a_mag) : w_b_mag};
          end else if (i_hilo_we && !i_start) begin
            if (i_hilo_sel) r_hi <= i_hilo_wdata;
            else            r_lo <= i_hilo_wdata;
          end
        end
        S_RUN: begin
          if (!i_flush) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!i_flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        S_ZDIV: begin
          if (!i_flush) begin
            r_hi   <= r_acc[W-1:0];
            r_lo   <= '1;
            r_done <= 1'b1;
            r_dbz  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_kim_muldiv_ctrl_p.sv
// Bench for kim_muldiv_ctrl_p: vector table of operations plus hand-written
// sequences for flush, ignored start, MTHI/MTLO gating and reset mid-op.
module tb_kim_muldiv_ctrl_p;

  logic        clk = 1'b0;
  logic        reset, start, flush, hilo_we, hilo_sel;
  logic [1:0]  op;
  logic [31:0] a, b, hilo_wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  kim_muldiv_ctrl_p #(.DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_flush(flush), .i_hilo_we(hilo_we), .i_hilo_sel(hilo_sel), .i_hilo_wdata(hilo_wdata),
    .o_busy(busy), .o_done(done), .o_div_by_zero(dbz), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done; returns cycles from start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      lat++;
    end
  endtask

  // Run with a budget and report whether done ever rose.
  task automatic watch_no_done(input int cycles, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int   lat;
    logic seen;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[6]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vecs[7]  = '{2'b01, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33};
    vecs[8]  = '{2'b10, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0, 33};
    vecs[9]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[10] = '{2'b00, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 33};
    vecs[11] = '{2'b11, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1};
    vecs[12] = '{2'b10, 32'd3,        32'd9,        32'd3,        32'd0,        1'b0, 33};

    reset = 1'b1; start = 1'b0; flush = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0;
    op = 2'b00; a = '0; b = '0; hilo_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz",  {31'd0, dbz},  32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Table-driven operations.
    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      tick();
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // MTLO / MTHI in idle.
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h0000CAFE;
    tick();
    hilo_sel = 1'b1; hilo_wdata = 32'h0000BEEF;
    tick();
    hilo_we = 1'b0;
    chk("mtlo", lo, 32'h0000CAFE);
    chk("mthi", hi, 32'h0000BEEF);

    // MTHI together with start is ignored; the op then completes normally.
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h11111111;
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    // MTHI while busy and a second start while busy are both ignored.
    hilo_wdata = 32'h22222222;
    tick(); tick();
    chk("mthi_busy_hi", hi, 32'h0000BEEF);
    hilo_we = 1'b0;
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      lat++;
    end
    chk("ign_start_lat", lat, 33);
    chk("ign_start_hi", hi, 32'd0);
    chk("ign_start_lo", lo, 32'd6);

    // Flush at RUN cycle 10: no done, HI/LO keep prior values.
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h0000CAFE;
    tick();
    hilo_we = 1'b0;
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    watch_no_done(40, seen);
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'h0000CAFE);

    // Flush and start in the same idle cycle: start dropped.
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN.
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    watch_no_done(40, seen);
    chk("rst_mid_no_done", {31'd0, seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
